// File: rtl/me_pkg.sv
// Shared motion-estimation types: SAD/MV widths, the result record and selector FSM states.
// Latency: none (types and constants only). Backpressure: n/a.
// ZMV_BIAS is only present when SAD_MIN_ZERO_BIAS_EN is defined.
package me_pkg;
    localparam int SAD_W    = 16;
    localparam int LANES    = 16;
    localparam int ROWS     = 16;
    localparam int SEARCH_R = 8;
    localparam int MV_W     = 5;
    localparam int LANE_W   = $clog2(LANES);
    localparam int ROW_W    = $clog2(ROWS);
    localparam int IDX_W    = 8;
`ifdef SAD_MIN_ZERO_BIAS_EN
    localparam int ZMV_BIAS = 64;
`endif

    typedef logic [SAD_W-1:0] sad_t;
    typedef logic [MV_W-1:0]  mv_t;

    typedef struct packed {
        sad_t             sad;
        mv_t              mv_x;
        mv_t              mv_y;
        logic [IDX_W-1:0] idx;
    } res_t;

    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;
endpackage

// File: rtl/sad_lane_min.sv
// LANES-to-1 unsigned minimum over one SAD beat, returning value and lowest lane on ties.
// Latency: combinational. Backpressure: none.
module sad_lane_min
    import me_pkg::*;
(
    input  logic [LANES*SAD_W-1:0] sad_vec,
    output sad_t                   min_sad,
    output logic [LANE_W-1:0]      min_lane
);
    // Strict less-than while scanning upward keeps the lowest lane on ties.
    always_comb begin
        min_sad  = sad_vec[0 +: SAD_W];
        min_lane = '0;
        for (int k = 1; k < LANES; k++) begin
            if (sad_vec[k*SAD_W +: SAD_W] < min_sad) begin
                min_sad  = sad_vec[k*SAD_W +: SAD_W];
                min_lane = LANE_W'(k);
            end
        end
    end
endmodule

// File: rtl/sad_min_selector.sv
// Running-minimum SAD selector over a 16x16 search window; emits best MV, SAD, index.
// Latency: best_valid 3 cycles after last-beat transfer; sad_ready low from then until result handshake.
// Backpressure: result held stable while best_ready low. Option: SAD_MIN_ZERO_BIAS_EN biases the (0,0) candidate.
module sad_min_selector
    import me_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sad_valid,
    output logic                   sad_ready,
    input  logic [LANES*SAD_W-1:0] sad_data,
    input  logic                   sad_last,
    output logic                   best_valid,
    input  logic                   best_ready,
    output logic [SAD_W-1:0]       best_sad,
    output logic [MV_W-1:0]        best_mv_x,
    output logic [MV_W-1:0]        best_mv_y,
    output logic [7:0]             best_idx,
    output logic                   len_err
);
    state_t              state, state_nxt;
    logic                rdy_en;
    logic                drain_cnt;
    logic [ROW_W-1:0]    row_cnt;
    logic                xfer, at_last_row, win_end, hs;
    logic [LANES*SAD_W-1:0] lane_vec;
    sad_t                lmin_sad;
    logic [LANE_W-1:0]   lmin_lane;
    logic                s1_vld, s1_first;
    sad_t                s1_sad;
    logic [LANE_W-1:0]   s1_lane;
    logic [ROW_W-1:0]    s1_row;
    res_t                s1_res, run;

    assign sad_ready   = (state == ACCUM) && rdy_en;
    assign xfer        = sad_valid && sad_ready;
    assign at_last_row = (row_cnt == ROW_W'(ROWS-1));
    assign win_end     = sad_last || at_last_row;
    assign best_valid  = (state == HOLD);
    assign hs          = best_valid && best_ready;

`ifdef SAD_MIN_ZERO_BIAS_EN
    sad_t zmv_raw;
    always_comb begin
        lane_vec = sad_data;
        zmv_raw  = sad_data[SEARCH_R*SAD_W +: SAD_W];
        if (row_cnt == ROW_W'(SEARCH_R)) begin
            lane_vec[SEARCH_R*SAD_W +: SAD_W] =
                (zmv_raw > sad_t'(ZMV_BIAS)) ? zmv_raw - sad_t'(ZMV_BIAS) : '0;
        end
    end
`else
    assign lane_vec = sad_data;
`endif

    sad_lane_min u_lane_min (
        .sad_vec  (lane_vec),
        .min_sad  (lmin_sad),
        .min_lane (lmin_lane)
    );

    always_comb begin
        s1_res.sad  = s1_sad;
        s1_res.mv_x = MV_W'(s1_lane) - MV_W'(SEARCH_R);
        s1_res.mv_y = MV_W'(s1_row) - MV_W'(SEARCH_R);
        s1_res.idx  = IDX_W'(s1_row) * IDX_W'(LANES) + IDX_W'(s1_lane);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (xfer && win_end) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt)       state_nxt = HOLD;
            HOLD:    if (best_ready)      state_nxt = ACCUM;
            default:                      state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_en    <= 1'b0;
            drain_cnt <= 1'b0;
            row_cnt   <= '0;
            s1_vld    <= 1'b0;
            s1_first  <= 1'b0;
            s1_sad    <= '0;
            s1_lane   <= '0;
            s1_row    <= '0;
            run       <= '0;
            len_err   <= 1'b0;
        end else begin
            rdy_en    <= 1'b1;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            s1_vld    <= xfer;
            if (xfer) begin
                s1_sad   <= lmin_sad;
                s1_lane  <= lmin_lane;
                s1_row   <= row_cnt;
                s1_first <= (row_cnt == '0);
                row_cnt  <= row_cnt + 1'b1;
                if (win_end) len_err <= (sad_last != at_last_row);
            end
            // First beat loads unconditionally; later rows only on strict improvement.
            if (s1_vld && (s1_first || s1_sad < run.sad)) run <= s1_res;
            if (hs) begin
                row_cnt <= '0;
                run     <= '0;
                len_err <= 1'b0;
            end
        end
    end

    assign best_sad  = run.sad;
    assign best_mv_x = run.mv_x;
    assign best_mv_y = run.mv_y;
    assign best_idx  = run.idx;
endmodule

// File: tb/tb_sad_min_selector.sv
// Table-driven bench for sad_min_selector: windows described by base value plus up to three
// special candidates, expected results queued on drive and popped at the result handshake.
module tb_sad_min_selector;
    import me_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst, sad_valid, sad_last, best_ready;
    logic                   sad_ready, best_valid, len_err;
    logic [LANES*SAD_W-1:0] sad_data;
    logic [SAD_W-1:0]       best_sad;
    logic [MV_W-1:0]        best_mv_x, best_mv_y;
    logic [7:0]             best_idx;

    always #5 clk = ~clk;

    sad_min_selector dut (
        .clk        (clk),
        .rst        (rst),
        .sad_valid  (sad_valid),
        .sad_ready  (sad_ready),
        .sad_data   (sad_data),
        .sad_last   (sad_last),
        .best_valid (best_valid),
        .best_ready (best_ready),
        .best_sad   (best_sad),
        .best_mv_x  (best_mv_x),
        .best_mv_y  (best_mv_y),
        .best_idx   (best_idx),
        .len_err    (len_err)
    );

    typedef struct {
        int nbeats; int use_last; int base;
        int r0, l0, v0, r1, l1, v1, r2, l2, v2;
        int rdy_dly;
        int e_sad, e_x, e_y, e_idx, e_err;
    } vec_t;

    typedef struct { int sad, x, y, idx, err; } exp_t;

    vec_t vt[8];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LANES*SAD_W-1:0] make_beat(input vec_t v, input int row);
        logic [LANES*SAD_W-1:0] d;
        int val;
        d = '0;
        for (int lane = 0; lane < LANES; lane++) begin
            val = v.base;
            if (row == v.r0 && lane == v.l0) val = v.v0;
            if (row == v.r1 && lane == v.l1) val = v.v1;
            if (row == v.r2 && lane == v.l2) val = v.v2;
            d[lane*SAD_W +: SAD_W] = SAD_W'(val);
        end
        return d;
    endfunction

    task automatic send_beat(input logic [LANES*SAD_W-1:0] d, input logic last);
        int t;
        if ($urandom_range(0, 3) == 0) begin
            sad_valid = 1'b0;
            tick();
        end
        sad_valid = 1'b1;
        sad_data  = d;
        sad_last  = last;
        t = 0;
        while (!sad_ready && t < 50) begin
            tick();
            t++;
        end
        if (!sad_ready) check("ready_timeout", 0, 1);
        tick();
        sad_valid = 1'b0;
        sad_last  = 1'b0;
    endtask

    task automatic run_window(input vec_t v, input int tag);
        exp_t e;
        int   lat, stable;
        logic [SAD_W-1:0] s_sad;
        logic [MV_W-1:0]  s_x, s_y;
        logic [7:0]       s_idx;
        e = '{v.e_sad, v.e_x, v.e_y, v.e_idx, v.e_err};
        sb.push_back(e);
        for (int b = 0; b < v.nbeats; b++)
            send_beat(make_beat(v, b), (v.use_last != 0) && (b == v.nbeats - 1));
        check($sformatf("w%0d_drain_ready", tag), int'(sad_ready), 0);
        lat = 1;
        while (!best_valid && lat < 20) begin
            tick();
            lat++;
        end
        check($sformatf("w%0d_latency", tag), lat, 3);
        s_sad = best_sad; s_x = best_mv_x; s_y = best_mv_y; s_idx = best_idx;
        stable = 1;
        for (int d = 0; d < v.rdy_dly; d++) begin
            tick();
            if (best_valid !== 1'b1 || sad_ready !== 1'b0 || best_sad !== s_sad ||
                best_mv_x !== s_x || best_mv_y !== s_y || best_idx !== s_idx)
                stable = 0;
        end
        if (v.rdy_dly > 0) check($sformatf("w%0d_hold_stable", tag), stable, 1);
        best_ready = 1'b1;
        e = sb.pop_front();
        check($sformatf("w%0d_sad", tag),     int'(best_sad), e.sad);
        check($sformatf("w%0d_mv_x", tag),    int'($signed(best_mv_x)), e.x);
        check($sformatf("w%0d_mv_y", tag),    int'($signed(best_mv_y)), e.y);
        check($sformatf("w%0d_idx", tag),     int'(best_idx), e.idx);
        check($sformatf("w%0d_len_err", tag), int'(len_err), e.err);
        tick();
        best_ready = 1'b0;
        check($sformatf("w%0d_valid_drop", tag), int'(best_valid), 0);
        check($sformatf("w%0d_ready_back", tag), int'(sad_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t pre;
        int   seen;
        vt[0] = '{16, 1, 1000,  3, 12, 5,  -1, 0, 0,  -1, 0, 0,  0,  5, 4, -5, 60, 0};
        vt[1] = '{16, 1, 1000,  2, 4, 7,   2, 9, 7,   10, 1, 7,  0,  7, -4, -6, 36, 0};
        vt[2] = '{16, 1, 65535, -1, 0, 0, -1, 0, 0,  -1, 0, 0,  10, 65535, -8, -8, 0, 0};
        vt[3] = '{6,  1, 1000,  4, 0, 20, -1, 0, 0,  -1, 0, 0,  0,  20, -8, -4, 64, 1};
        vt[4] = '{16, 0, 500,   15, 15, 3, -1, 0, 0, -1, 0, 0,  2,  3, 7, 7, 255, 1};
`ifdef SAD_MIN_ZERO_BIAS_EN
        vt[5] = '{16, 1, 1000,  0, 0, 50,  8, 8, 100, -1, 0, 0, 0,  36, 0, 0, 136, 0};
`else
        vt[5] = '{16, 1, 1000,  0, 0, 50,  8, 8, 100, -1, 0, 0, 0,  50, -8, -8, 0, 0};
`endif
        vt[6] = '{16, 1, 200,   0, 15, 9,  15, 0, 9,  -1, 0, 0, 0,  9, 7, -8, 15, 0};
        vt[7] = '{16, 1, 1,     7, 7, 0,  -1, 0, 0,  -1, 0, 0,  0,  0, -1, -1, 119, 0};
        pre   = '{16, 1, 1,    -1, 0, 0,  -1, 0, 0,  -1, 0, 0,  0,  0, 0, 0, 0, 0};

        rst = 1'b1; sad_valid = 1'b0; sad_last = 1'b0; sad_data = '0; best_ready = 1'b0;
        tick();
        tick();
        check("rst_sad_ready", int'(sad_ready), 0);
        check("rst_best_valid", int'(best_valid), 0);
        check("rst_best_sad", int'(best_sad), 0);
        check("rst_mv_x", int'(best_mv_x), 0);
        check("rst_mv_y", int'(best_mv_y), 0);
        check("rst_idx", int'(best_idx), 0);
        check("rst_len_err", int'(len_err), 0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", int'(sad_ready), 1);

        for (int i = 0; i < 8; i++) run_window(vt[i], i);

        // Partial window of small SADs, then reset on beat 8.
        for (int b = 0; b < 8; b++) send_beat(make_beat(pre, b), 1'b0);
        sad_valid = 1'b1;
        sad_data  = make_beat(pre, 8);
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        sad_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (best_valid) seen = 1;
        end
        check("midrst_no_result", seen, 0);
        check("midrst_best_sad", int'(best_sad), 0);
        run_window(vt[0], 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
